// File: rtl/data_memory_be.sv
// MEM-stage data memory with byte/half/word stores using byte-lane masks and extended sub-word
// loads. Misaligned accesses are flagged. Load latency is set by READ_LAT (1 or 2).
module data_memory_be #(
    parameter int unsigned DWIDTH   = 32,
    parameter int unsigned AWIDTH   = 12,
    parameter int unsigned READ_LAT = 1
) (
    input  logic              m_clk,
    input  logic              m_rst,
    input  logic              m_i_ce,
    input  logic              m_wr_en,
    input  logic              m_rd_en,
    input  logic [1:0]        m_i_size,
    input  logic              m_i_unsigned,
    input  logic [AWIDTH-1:0] alu_value_addr,
    input  logic [DWIDTH-1:0] m_i_store_data,
    output logic [DWIDTH-1:0] m_o_load_data,
    output logic              m_o_load_valid,
    output logic              m_o_misaligned
);

    localparam int unsigned DEPTH = 2 ** (AWIDTH - 2);

    logic [DWIDTH-1:0] mem [DEPTH];

    logic [AWIDTH-3:0] word_idx;
    logic [1:0]        lane;
    logic              accept;
    logic              store;
    logic              load;
    logic              misaligned;
    logic [3:0]        byte_en;
    logic [DWIDTH-1:0] wdata;
    logic [DWIDTH-1:0] rd_word;

    logic [DWIDTH-1:0] data_q;
    logic              valid_q;
    logic              mis_q;

    assign word_idx = alu_value_addr[AWIDTH-1:2];
    assign lane     = alu_value_addr[1:0];
    assign accept   = m_i_ce & (m_wr_en | m_rd_en);
    // A simultaneous read and write is treated as a store only.
    assign store    = accept & m_wr_en;
    assign load     = accept & m_rd_en & ~m_wr_en;
    assign rd_word  = mem[word_idx];

    always_comb begin
        misaligned = 1'b1;
        byte_en    = 4'b0000;
        wdata      = m_i_store_data;
        case (m_i_size)
            2'b00: begin
                misaligned = 1'b0;
                byte_en    = 4'b0001 << lane;
                wdata      = {4{m_i_store_data[7:0]}};
            end
            2'b01: begin
                misaligned = lane[0];
                byte_en    = lane[1] ? 4'b1100 : 4'b0011;
                wdata      = {2{m_i_store_data[15:0]}};
            end
            2'b10: begin
                misaligned = (lane != 2'b00);
                byte_en    = 4'b1111;
            end
            default: begin
                misaligned = 1'b1;
                byte_en    = 4'b0000;
            end
        endcase
    end

    // Array has no reset; writes are simply blocked while reset is held.
    always_ff @(posedge m_clk) begin
        if (m_rst && store && !misaligned) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) mem[word_idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    function automatic logic [DWIDTH-1:0] extend(input logic [DWIDTH-1:0] word,
                                                 input logic [1:0] ln,
                                                 input logic [1:0] sz,
                                                 input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[8*ln +: 8];
        h = ln[1] ? word[31:16] : word[15:0];
        case (sz)
            2'b00:   extend = {{24{b[7] & ~uns}}, b};
            2'b01:   extend = {{16{h[15] & ~uns}}, h};
            default: extend = word;
        endcase
    endfunction

    if (READ_LAT == 1) begin : g_lat1
        always_ff @(posedge m_clk or negedge m_rst) begin
            if (!m_rst) begin
                data_q  <= '0;
                valid_q <= 1'b0;
                mis_q   <= 1'b0;
            end else begin
                valid_q <= load;
                mis_q   <= accept & misaligned;
                data_q  <= (load && !misaligned) ?
                           extend(rd_word, lane, m_i_size, m_i_unsigned) : '0;
            end
        end
    end else begin : g_lat2
        logic              s1_valid;
        logic              s1_mis;
        logic              s1_uns;
        logic [DWIDTH-1:0] s1_word;
        logic [1:0]        s1_lane;
        logic [1:0]        s1_size;

        always_ff @(posedge m_clk or negedge m_rst) begin
            if (!m_rst) begin
                s1_valid <= 1'b0;
                s1_mis   <= 1'b0;
                s1_uns   <= 1'b0;
                s1_word  <= '0;
                s1_lane  <= 2'b00;
                s1_size  <= 2'b00;
                data_q   <= '0;
                valid_q  <= 1'b0;
                mis_q    <= 1'b0;
            end else begin
                s1_valid <= load;
                s1_mis   <= load & misaligned;
                s1_uns   <= m_i_unsigned;
                s1_word  <= rd_word;
                s1_lane  <= lane;
                s1_size  <= m_i_size;
                valid_q  <= s1_valid;
                // Store misalignment is reported one cycle after acceptance, like a 1-cycle load.
                mis_q    <= (store & misaligned) | (s1_valid & s1_mis);
                data_q   <= (s1_valid && !s1_mis) ?
                            extend(s1_word, s1_lane, s1_size, s1_uns) : '0;
            end
        end
    end

    assign m_o_load_data  = data_q;
    assign m_o_load_valid = valid_q;
    assign m_o_misaligned = mis_q;

endmodule

// File: tb/tb_data_memory_be.sv
// Bench for data_memory_be: one READ_LAT=1 and one READ_LAT=2 instance share stimulus and are
// checked against a byte-array reference model.
module tb_data_memory_be;

    localparam int AW = 12;

    logic          m_clk = 1'b0;
    logic          m_rst = 1'b0;
    logic          m_i_ce = 1'b0;
    logic          m_wr_en = 1'b0;
    logic          m_rd_en = 1'b0;
    logic [1:0]    m_i_size = 2'b00;
    logic          m_i_unsigned = 1'b0;
    logic [AW-1:0] alu_value_addr = '0;
    logic [31:0]   m_i_store_data = '0;

    logic [31:0] ld1, ld2;
    logic        v1, v2, mis1, mis2;

    data_memory_be #(.DWIDTH(32), .AWIDTH(AW), .READ_LAT(1)) u_dut1 (
        .m_clk          (m_clk),
        .m_rst          (m_rst),
        .m_i_ce         (m_i_ce),
        .m_wr_en        (m_wr_en),
        .m_rd_en        (m_rd_en),
        .m_i_size       (m_i_size),
        .m_i_unsigned   (m_i_unsigned),
        .alu_value_addr (alu_value_addr),
        .m_i_store_data (m_i_store_data),
        .m_o_load_data  (ld1),
        .m_o_load_valid (v1),
        .m_o_misaligned (mis1)
    );

    data_memory_be #(.DWIDTH(32), .AWIDTH(AW), .READ_LAT(2)) u_dut2 (
        .m_clk          (m_clk),
        .m_rst          (m_rst),
        .m_i_ce         (m_i_ce),
        .m_wr_en        (m_wr_en),
        .m_rd_en        (m_rd_en),
        .m_i_size       (m_i_size),
        .m_i_unsigned   (m_i_unsigned),
        .alu_value_addr (alu_value_addr),
        .m_i_store_data (m_i_store_data),
        .m_o_load_data  (ld2),
        .m_o_load_valid (v2),
        .m_o_misaligned (mis2)
    );

    always #5 m_clk = ~m_clk;

    logic [7:0]  mref [2**AW];
    int          n_vec = 0;
    int          n_err = 0;
    // Load response still in flight for the 2-cycle instance.
    logic        p_v = 1'b0;
    logic        p_mis = 1'b0;
    logic [31:0] p_d = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int nbytes(input logic [1:0] size);
        return (size == 2'd3) ? 1 : (1 << size);
    endfunction

    function automatic logic ref_misal(input logic [1:0] size, input logic [AW-1:0] addr);
        return (size == 2'd3) || ((int'(addr) % nbytes(size)) != 0);
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] size, input logic uns,
                                             input logic [AW-1:0] addr);
        logic [31:0] w;
        int          n;
        n = nbytes(size);
        w = '0;
        for (int i = 0; i < n; i++) w = w | (32'(mref[int'(addr) + i]) << (8 * i));
        if (n == 1 && !uns && w[7])  w = w | 32'hFFFF_FF00;
        if (n == 2 && !uns && w[15]) w = w | 32'hFFFF_0000;
        return w;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_d1"}, ld1, 32'h0);
        check({tag, "_v1"}, 32'(v1), 32'h0);
        check({tag, "_m1"}, 32'(mis1), 32'h0);
        check({tag, "_d2"}, ld2, 32'h0);
        check({tag, "_v2"}, 32'(v2), 32'h0);
        check({tag, "_m2"}, 32'(mis2), 32'h0);
    endtask

    // Called just after a falling edge: drive one cycle, then check both instances.
    task automatic step(input logic ce, input logic wr, input logic rd, input logic [1:0] size,
                        input logic uns, input logic [AW-1:0] addr, input logic [31:0] data);
        logic        st, ld, mis, ld_v, ld_mis, st_mis;
        logic [31:0] ld_d;
        m_i_ce         = ce;
        m_wr_en        = wr;
        m_rd_en        = rd;
        m_i_size       = size;
        m_i_unsigned   = uns;
        alu_value_addr = addr;
        m_i_store_data = data;
        st     = ce && wr;
        ld     = ce && rd && !wr;
        mis    = ref_misal(size, addr);
        ld_v   = ld;
        ld_mis = ld && mis;
        st_mis = st && mis;
        ld_d   = (ld && !mis) ? ref_load(size, uns, addr) : 32'h0;
        @(posedge m_clk);
        if (st && !mis) begin
            for (int i = 0; i < nbytes(size); i++)
                mref[int'(addr) + i] = 8'(data >> (8 * i));
        end
        @(negedge m_clk);
        check("lat1_data", ld1, ld_d);
        check("lat1_valid", 32'(v1), 32'(ld_v));
        check("lat1_misal", 32'(mis1), 32'(ld_mis | st_mis));
        check("lat2_data", ld2, p_d);
        check("lat2_valid", 32'(v2), 32'(p_v));
        check("lat2_misal", 32'(mis2), 32'(p_mis | st_mis));
        p_v   = ld_v;
        p_mis = ld_mis;
        p_d   = ld_d;
    endtask

    task automatic randomize_inputs();
        m_i_ce         = 1'($urandom);
        m_wr_en        = 1'($urandom);
        m_rd_en        = 1'($urandom);
        m_i_size       = 2'($urandom);
        m_i_unsigned   = 1'($urandom);
        alu_value_addr = AW'($urandom);
        m_i_store_data = $urandom;
    endtask

    // Called just after a falling edge; returns at a falling edge with reset released.
    task automatic do_reset(input int cycles);
        m_rst = 1'b0;
        #1;
        check_idle("rst_async");
        for (int c = 0; c < cycles; c++) begin
            randomize_inputs();
            @(negedge m_clk);
            check_idle("rst_hold");
        end
        m_i_ce  = 1'b0;
        m_wr_en = 1'b0;
        m_rd_en = 1'b0;
        m_rst   = 1'b1;
        p_v     = 1'b0;
        p_mis   = 1'b0;
        p_d     = '0;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, '0, '0);
    endtask

    task automatic sw(input logic [AW-1:0] a, input logic [31:0] d);
        step(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, a, d);
    endtask

    task automatic ldx(input logic [1:0] size, input logic uns, input logic [AW-1:0] a);
        step(1'b1, 1'b0, 1'b1, size, uns, a, '0);
    endtask

    initial begin
        for (int i = 0; i < 2**AW; i++) mref[i] = 8'h00;
        randomize_inputs();
        @(negedge m_clk);
        do_reset(2);

        // Give the whole array a known value so every later load is defined.
        for (int w = 0; w < 2**(AW-2); w++) sw(AW'(4 * w), 32'h0);

        sw(12'h010, 32'hDEAD_BEEF);
        ldx(2'd2, 1'b0, 12'h010);
        idle();

        sw(12'h020, 32'h0);
        step(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 12'h021, 32'h0000_0080);
        ldx(2'd2, 1'b0, 12'h020);
        ldx(2'd0, 1'b0, 12'h021);
        ldx(2'd0, 1'b1, 12'h021);

        sw(12'h030, 32'h1234_5678);
        step(1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 12'h032, 32'h0000_8001);
        ldx(2'd2, 1'b0, 12'h030);
        ldx(2'd1, 1'b0, 12'h032);
        ldx(2'd1, 1'b1, 12'h032);

        sw(12'h040, 32'hAAAA_AAAA);
        step(1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 12'h043, 32'h0000_1234);
        ldx(2'd2, 1'b0, 12'h040);
        ldx(2'd2, 1'b0, 12'h041);
        idle();

        sw(12'h050, 32'h1122_3344);
        ldx(2'd2, 1'b0, 12'h050);
        // A store right behind a load must not affect that load's result.
        ldx(2'd2, 1'b0, 12'h050);
        sw(12'h050, 32'h5566_7788);
        ldx(2'd2, 1'b0, 12'h050);
        step(1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 12'h054, 32'hCAFE_F00D);
        ldx(2'd2, 1'b0, 12'h054);
        idle();

        for (int i = 0; i < 10; i++) ldx(2'd2, 1'b0, AW'(4 * i));
        idle();

        ldx(2'd2, 1'b0, 12'h010);
        ldx(2'd2, 1'b0, 12'h020);
        do_reset(2);
        idle();
        idle();

        for (int i = 0; i < 800; i++) begin
            step(($urandom % 8) != 0, ($urandom % 3) == 0, 1'($urandom),
                 (($urandom % 6) == 0) ? 2'd3 : 2'($urandom % 3), 1'($urandom),
                 AW'($urandom_range(0, 127)), $urandom);
            if (i == 400) do_reset(2);
        end
        idle();
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/data_memory_be.md
# data_memory_be

Parametrised data memory for the MEM stage of the MIPS pipeline, successor to the single-width word memory. Adds byte/halfword/word stores with byte-lane masking, sign- or zero-extended sub-word loads, misalignment detection, and a configurable registered read latency (1 or 2 cycles) with a load-valid strobe. Sits between the EX/MEM pipeline register (`alu_value_addr`, store data, control) and the MEM/WB register (load data).

## Interface

Parameters:
- `DWIDTH`, 32: data word width; fixed by the ISA, only 32 is supported.
- `AWIDTH`, 12: byte-address width. Depth is 2^(`AWIDTH`-2) words.
- `READ_LAT`, 1: load latency in cycles. Legal values are 1 and 2.

Ports:
- `m_clk`, in, 1: clock, rising edge.
- `m_rst`, in, 1: reset, asynchronous, active-low.
- `m_i_ce`, in, 1: chip enable. When 0, no new access is accepted.
- `m_wr_en`, in, 1: store request.
- `m_rd_en`, in, 1: load request.
- `m_i_size`, in, 2: access size. 00 = byte, 01 = half, 10 = word, 11 = illegal.
- `m_i_unsigned`, in, 1: load extension mode. 1 = zero-extend, 0 = sign-extend.
- `alu_value_addr`, in, `AWIDTH`: byte address.
- `m_i_store_data`, in, 32: store data, right-aligned; a byte store uses bits [7:0].
- `m_o_load_data`, out, 32: extended load result.
- `m_o_load_valid`, out, 1: one-cycle strobe marking a load response.
- `m_o_misaligned`, out, 1: one-cycle error strobe.

## Operation

- **Accepted access:** `m_i_ce`=1 and (`m_wr_en` or `m_rd_en`), sampled at the rising edge.
- **Simultaneous read and write:** if both `m_wr_en` and `m_rd_en` are 1, the access is a store only. No load response is produced.
- **Word index and byte lane:** word index = `alu_value_addr`[AWIDTH-1:2]. Byte lane = `alu_value_addr`[1:0]. Little-endian: lane 0 is bits [7:0].
- **Misaligned access:**
  - Conditions: half with addr[0]=1, word with addr[1:0]≠0, or size=11.
  - Misaligned store: the array is not modified.
  - Misaligned load: responds with `m_o_load_data`=0, `m_o_load_valid`=1 and `m_o_misaligned`=1 in the same cycle.
- **Store:**
  - Byte store writes only lane addr[1:0] with data[7:0].
  - Half store writes lanes {addr[1],0} and {addr[1],1} with data[15:0].
  - Word store writes all four lanes.
  - Unwritten lanes keep their value.
- **Load:**
  - Reads the whole word, then selects the lane.
  - Byte: sign or zero extension from bit 7 of the selected byte, per `m_i_unsigned`.
  - Half: sign or zero extension from bit 15 of the selected half, per `m_i_unsigned`.
  - Word: returned unmodified; `m_i_unsigned` is ignored.
- **Load pipeline:**
  - `READ_LAT`=1: one stage; the array read and the extension happen in the registered path.
  - `READ_LAT`=2: stage 1 registers the raw word, lane, size and unsigned flag. Stage 2 registers the extended result.
  - Each stage carries its own valid bit. One load per cycle is sustained, with no bubbles.
- **Chip enable low:** `m_i_ce`=0 does not stall or flush the pipeline. Loads already in flight still complete.
- **Array contents:** not reset; contents are undefined until written.
- **Reset:** while `m_rst`=0:
  - `m_o_load_data`=0, `m_o_load_valid`=0, `m_o_misaligned`=0.
  - All pipeline valid bits are cleared.
  - Reset asserted mid-stream drops in-flight loads; no valid is produced for them after release.

## Timing

- **Store:** the array updates at edge T. A load accepted at edge T+1 to the same word returns the new data.
- **Store and load in the same cycle:** the access is a store only (see Operation); no load is issued.
- **Load accepted at edge T:** `m_o_load_data` and `m_o_load_valid` are valid after edge T+`READ_LAT`, for exactly one cycle.
- **Ordering with `READ_LAT`=2:** a store accepted at T+1 does not alter the result of a load accepted at T.
- **Misaligned store:** `m_o_misaligned` pulses after edge T+1, regardless of `READ_LAT`.
- **Misaligned load:** `m_o_misaligned` pulses together with its `m_o_load_valid`, after edge T+`READ_LAT`.
- **Idle outputs:** `m_o_load_data` holds 0 whenever `m_o_load_valid`=0. `m_o_misaligned`=0 outside its pulse.

## Test plan

Run every scenario for both `READ_LAT`=1 and `READ_LAT`=2.

- **Reset:** hold `m_rst`=0 for 2 cycles with random inputs -> `m_o_load_data`=0, `m_o_load_valid`=0, `m_o_misaligned`=0 throughout.
- **Word store/load:** sw 0xDEADBEEF at 0x010, then lw 0x010 -> 0xDEADBEEF with `m_o_load_valid`=1 exactly `READ_LAT` cycles after acceptance.
- **Byte store and byte loads:**
  - Setup: sw 0 at 0x020, then sb 0x80 at 0x021.
  - lw 0x020 -> 0x00008000.
  - lb 0x021 -> 0xFFFFFF80.
  - lbu 0x021 -> 0x00000080.
- **Half store and half loads:**
  - Setup: sw 0x12345678 at 0x030, then sh 0x8001 at 0x032.
  - lw 0x030 -> 0x80015678.
  - lh 0x032 -> 0xFFFF8001.
  - lhu 0x032 -> 0x00008001.
- **Misalignment:**
  - Setup: sw 0xAAAAAAAA at 0x040.
  - sh 0x1234 at 0x043 -> `m_o_misaligned` pulses; lw 0x040 still returns 0xAAAAAAAA.
  - lw 0x041 -> data 0 with valid=1 and misaligned=1 in the same cycle.
- **Streaming and reset mid-stream:**
  - sw 0x11223344 at 0x050 at edge T, lw 0x050 at T+1 -> 0x11223344.
  - 10 back-to-back lw from 0x000-0x024 -> 10 consecutive valid cycles, in order.
  - Assert `m_rst` while loads are in flight -> no `m_o_load_valid` after release.
